// File: rtl/hazard_unit_sb_pkg.sv
// Shared types and defaults for the pipeline hazard unit with long-op scoreboard.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hazard_pkg;

    // Forwarding mux select for E-stage operands.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // ResultSrc encoding that marks a load in E.
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam int NREG_DEF       = 32;
    localparam int LONG_DEPTH_DEF = 2;
    localparam int PERF_W_DEF     = 32;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Hazard bus between the 5-stage datapath and the hazard unit.
// Latency: none (wires only); master = datapath, slave = hazard unit.
// Backpressure: Stall_*/Flush_* are the hold/bubble controls returned to the datapath.
// Perf* signals and the PERF_W parameter exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_sb_if
    import hazard_pkg::*;
#(
    parameter int RAW = 5
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = PERF_W_DEF
`endif
) ();

    // Pipeline state reported by the datapath
    logic           RegWrite_M;
    logic           RegWrite_W;
    logic [RAW-1:0] rdest_E;
    logic [RAW-1:0] rdest_M;
    logic [RAW-1:0] rdest_W;
    logic [RAW-1:0] rs1_D;
    logic [RAW-1:0] rs2_D;
    logic [RAW-1:0] rs1_E;
    logic [RAW-1:0] rs2_E;
    logic [RAW-1:0] rdest_D;
    logic [1:0]     ResultSrc_E;
    logic           PCSrc_E;
    logic           LongOp_D;
    logic           LongOp_E;
    logic           LongDone;
    logic [RAW-1:0] LongRd;
    logic           MemReq_M;
    logic           DmemReady;

    // Controls returned by the hazard unit
    fwd_sel_e       ForwardA_E;
    fwd_sel_e       ForwardB_E;
    logic           Stall_F;
    logic           Stall_D;
    logic           Stall_E;
    logic           Stall_M;
    logic           Flush_D;
    logic           Flush_E;
    logic           Flush_W;
    logic           LongIssue;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] PerfLw;
    logic [PERF_W-1:0] PerfSb;
    logic [PERF_W-1:0] PerfMem;
    logic [PERF_W-1:0] PerfFlush;
`endif

    modport master (
        output RegWrite_M, RegWrite_W, rdest_E, rdest_M, rdest_W,
               rs1_D, rs2_D, rs1_E, rs2_E, rdest_D, ResultSrc_E, PCSrc_E,
               LongOp_D, LongOp_E, LongDone, LongRd, MemReq_M, DmemReady,
        input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W, LongIssue
`ifdef HAZARD_PERF_EN
        , input PerfLw, PerfSb, PerfMem, PerfFlush
`endif
    );

    modport slave (
        input  RegWrite_M, RegWrite_W, rdest_E, rdest_M, rdest_W,
               rs1_D, rs2_D, rs1_E, rs2_E, rdest_D, ResultSrc_E, PCSrc_E,
               LongOp_D, LongOp_E, LongDone, LongRd, MemReq_M, DmemReady,
        output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
               Flush_D, Flush_E, Flush_W, LongIssue
`ifdef HAZARD_PERF_EN
        , output PerfLw, PerfSb, PerfMem, PerfFlush
`endif
    );

endinterface

// File: rtl/hazard_unit_sb_scoreboard.sv
// Register scoreboard for the variable-latency long-op unit: pending bitmap + outstanding count.
// Latency: lookup (stall) is combinational; issue/done take effect on the next clk edge.
// Backpressure: stall holds D while a source/dest is pending or the unit is full.
// Ports: clk, reset (sync, active-high); issue/issue_rd and done/done_rd update state;
//        long_op_d, rs1, rs2, rd are the D-stage lookup; stall is the scoreboard hazard.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int RAW        = $clog2(NREG),
    parameter int LONG_DEPTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           issue,
    input  logic [RAW-1:0] issue_rd,
    input  logic           done,
    input  logic [RAW-1:0] done_rd,
    input  logic           long_op_d,
    input  logic [RAW-1:0] rs1,
    input  logic [RAW-1:0] rs2,
    input  logic [RAW-1:0] rd,
    output logic           stall
);

    localparam int              CNT_W = $clog2(LONG_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LONG_DEPTH);

    logic [NREG-1:0]  pending;
    logic [NREG-1:0]  pending_nxt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic             done_ok;
    logic             inc;

    // A completion with nothing outstanding is a protocol error and is ignored.
    assign done_ok = done && (outstanding != '0);
    // Never count past the depth; a same-cycle completion frees the slot being taken.
    assign inc     = issue && ((outstanding != FULL) || done_ok);

    always_comb begin
        pending_nxt     = pending;
        outstanding_nxt = outstanding;
        // Clear first so a same-register issue in this cycle re-sets the bit.
        if (done_ok) begin
            pending_nxt[done_rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        if (inc && !done_ok) begin
            outstanding_nxt = outstanding + CNT_W'(1);
        end else if (done_ok && !inc) begin
            outstanding_nxt = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            outstanding <= '0;
        end else begin
            pending     <= pending_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    // x0 is never marked pending, so raw lookups on rs1/rs2 are safe; rd needs the
    // explicit guard only for readability of the WAW term.
    assign stall = pending[rs1] | pending[rs2] |
                   (pending[rd] && (rd != '0)) |
                   (long_op_d && (outstanding == FULL));

    a_done_underflow: assert property (@(posedge clk) disable iff (reset)
        !(done && (outstanding == '0)));

endmodule

// File: rtl/hazard_unit_sb.sv
// Pipeline hazard unit: M/W forwarding, load-use and long-op scoreboard stalls, branch flush, dmem freeze.
// Latency: all forwarding/stall/flush outputs are combinational (zero cycles); scoreboard/counters update on clk.
// Backpressure: dmem wait freezes F..M and bubbles W; load-use/scoreboard hazards hold F/D and bubble E.
// Ports: clk, reset (sync, active-high), hz (hazard_unit_sb_if.slave).
// Optional feature: HAZARD_PERF_EN adds saturating PerfLw/PerfSb/PerfMem/PerfFlush counters.
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int NREG       = NREG_DEF,
    parameter int RAW        = $clog2(NREG),
    parameter int LONG_DEPTH = LONG_DEPTH_DEF,
    parameter int PERF_W     = PERF_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    hazard_unit_sb_if.slave hz
);

    logic mem_stall;
    logic lw_stall;
    logic sb_stall;
    logic hold_d;
    logic long_issue;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    // Newest producer wins: M is younger than W. x0 never forwards.
    function automatic fwd_sel_e fwd_pick(
        input logic [RAW-1:0] src,
        input logic [RAW-1:0] rd_m,
        input logic           we_m,
        input logic [RAW-1:0] rd_w,
        input logic           we_w
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (we_m && (rd_m == src)) begin
                sel = FWD_M;
            end else if (we_w && (rd_w == src)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign hz.ForwardA_E = fwd_pick(hz.rs1_E, hz.rdest_M, hz.RegWrite_M, hz.rdest_W, hz.RegWrite_W);
    assign hz.ForwardB_E = fwd_pick(hz.rs2_E, hz.rdest_M, hz.RegWrite_M, hz.rdest_W, hz.RegWrite_W);

    assign mem_stall = hz.MemReq_M && !hz.DmemReady;
    assign lw_stall  = (hz.ResultSrc_E == RESULT_LOAD) && (hz.rdest_E != '0) &&
                       ((hz.rs1_D == hz.rdest_E) || (hz.rs2_D == hz.rdest_E));
    assign hold_d    = lw_stall | sb_stall;

    // The E instruction leaves E unless the whole pipe is frozen on memory.
    assign long_issue = hz.LongOp_E && !mem_stall && !reset;

    hazard_scoreboard #(
        .NREG       (NREG),
        .RAW        (RAW),
        .LONG_DEPTH (LONG_DEPTH)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .issue     (long_issue),
        .issue_rd  (hz.rdest_E),
        .done      (hz.LongDone),
        .done_rd   (hz.LongRd),
        .long_op_d (hz.LongOp_D),
        .rs1       (hz.rs1_D),
        .rs2       (hz.rs2_D),
        .rd        (hz.rdest_D),
        .stall     (sb_stall)
    );

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            // Full freeze; a taken branch waits in E and flushes once M drains.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            // With a taken branch the held D instruction is wrong-path and gets flushed too.
            stall_f = hold_d;
            stall_d = hold_d;
            flush_e = hold_d | hz.PCSrc_E;
            flush_d = hz.PCSrc_E;
        end
    end

    assign hz.Stall_F   = stall_f;
    assign hz.Stall_D   = stall_d;
    assign hz.Stall_E   = stall_e;
    assign hz.Stall_M   = stall_m;
    assign hz.Flush_D   = flush_d;
    assign hz.Flush_E   = flush_e;
    assign hz.Flush_W   = flush_w;
    assign hz.LongIssue = long_issue;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lw;
    logic [PERF_W-1:0] perf_sb;
    logic [PERF_W-1:0] perf_mem;
    logic [PERF_W-1:0] perf_flush;

    // Each counter saturates at all-ones; stall causes are attributed to the
    // highest-priority source only.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lw    <= '0;
            perf_sb    <= '0;
            perf_mem   <= '0;
            perf_flush <= '0;
        end else begin
            if (mem_stall && (perf_mem != '1)) begin
                perf_mem <= perf_mem + PERF_W'(1);
            end
            if (!mem_stall && lw_stall && (perf_lw != '1)) begin
                perf_lw <= perf_lw + PERF_W'(1);
            end
            if (!mem_stall && !lw_stall && sb_stall && (perf_sb != '1)) begin
                perf_sb <= perf_sb + PERF_W'(1);
            end
            if (flush_d && (perf_flush != '1)) begin
                perf_flush <= perf_flush + PERF_W'(1);
            end
        end
    end

    assign hz.PerfLw    = perf_lw;
    assign hz.PerfSb    = perf_sb;
    assign hz.PerfMem   = perf_mem;
    assign hz.PerfFlush = perf_flush;
`endif

    a_param_range: assert property (@(posedge clk)
        (LONG_DEPTH >= 1) && (LONG_DEPTH <= 7) && (PERF_W >= 1));

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: constant vector table, directed multi-cycle sequences,
// and randomized cycles against a queue-based reference model of outstanding long ops.
// Optional perf counters are checked when HAZARD_PERF_EN is defined.
module tb_hazard_unit_sb;
    import hazard_pkg::*;

    localparam int LD   = 2;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_sb_if #(
        .RAW(5)
`ifdef HAZARD_PERF_EN
        , .PERF_W(PW)
`endif
    ) hz ();

    hazard_unit_sb #(
        .NREG       (32),
        .LONG_DEPTH (LD),
        .PERF_W     (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct packed {
        logic       wm, ww;
        logic [4:0] rdE, rdM, rdW, rs1D, rs2D, rs1E, rs2E, rdD;
        logic [1:0] res;
        logic       pc, lopD, lopE, ldone;
        logic [4:0] lrd;
        logic       mreq, mrdy;
    } in_t;

    typedef struct packed {
        logic [1:0] fa, fb;
        logic       sf, sd, se, sm, fd, fe, fw, li;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    int   q[$];        // destinations of accepted, not yet completed long ops
    int   pm, pl, ps, pf;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        v.mrdy = 1'b1;
        return v;
    endfunction

    function automatic out_t mk(int fa, int fb, bit sf, bit sd, bit se, bit sm,
                                bit fd, bit fe, bit fw, bit li);
        out_t o;
        o.fa = 2'(fa); o.fb = 2'(fb);
        o.sf = sf; o.sd = sd; o.se = se; o.sm = sm;
        o.fd = fd; o.fe = fe; o.fw = fw; o.li = li;
        return o;
    endfunction

    function automatic bit pend(int r);
        if (r == 0) return 1'b0;
        foreach (q[k]) if (q[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int fwd(int src, int rdm, bit wm, int rdw, bit ww);
        if (src == 0) return 0;
        if (wm && rdm == src) return 2;
        if (ww && rdw == src) return 1;
        return 0;
    endfunction

    function automatic bit m_lw(in_t v);
        return (v.res == 2'b01) && (v.rdE != 0) && (v.rs1D == v.rdE || v.rs2D == v.rdE);
    endfunction

    function automatic bit m_sb(in_t v);
        return pend(int'(v.rs1D)) || pend(int'(v.rs2D)) || pend(int'(v.rdD)) ||
               (v.lopD && q.size() == LD);
    endfunction

    function automatic out_t model_out(in_t v, logic rst);
        out_t o;
        bit mem, hold;
        o = '0;
        o.fa = 2'(fwd(int'(v.rs1E), int'(v.rdM), v.wm, int'(v.rdW), v.ww));
        o.fb = 2'(fwd(int'(v.rs2E), int'(v.rdM), v.wm, int'(v.rdW), v.ww));
        mem  = v.mreq && !v.mrdy;
        hold = m_lw(v) || m_sb(v);
        if (rst) begin
            o.fd = 1; o.fe = 1; o.fw = 1;
        end else if (mem) begin
            o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
        end else begin
            o.sf = hold; o.sd = hold; o.fe = hold || v.pc; o.fd = v.pc;
        end
        o.li = v.lopE && !mem && !rst;
        return o;
    endfunction

    task automatic model_update(in_t v, logic rst, out_t e);
        bit mem;
        if (rst) begin
            q.delete();
            pm = 0; pl = 0; ps = 0; pf = 0;
            return;
        end
        mem = v.mreq && !v.mrdy;
        if (mem) begin
            if (pm < PMAX) pm++;
        end else if (m_lw(v)) begin
            if (pl < PMAX) pl++;
        end else if (m_sb(v)) begin
            if (ps < PMAX) ps++;
        end
        if (e.fd && pf < PMAX) pf++;
        if (v.ldone) begin
            for (int k = 0; k < q.size(); k++) begin
                if (q[k] == int'(v.lrd)) begin
                    q.delete(k);
                    break;
                end
            end
        end
        if (v.lopE && !mem) q.push_back(int'(v.rdE));
    endtask

    task automatic apply(in_t v);
        hz.RegWrite_M  = v.wm;   hz.RegWrite_W = v.ww;
        hz.rdest_E     = v.rdE;  hz.rdest_M    = v.rdM;  hz.rdest_W = v.rdW;
        hz.rs1_D       = v.rs1D; hz.rs2_D      = v.rs2D;
        hz.rs1_E       = v.rs1E; hz.rs2_E      = v.rs2E;
        hz.rdest_D     = v.rdD;  hz.ResultSrc_E = v.res;
        hz.PCSrc_E     = v.pc;   hz.LongOp_D   = v.lopD; hz.LongOp_E = v.lopE;
        hz.LongDone    = v.ldone; hz.LongRd    = v.lrd;
        hz.MemReq_M    = v.mreq; hz.DmemReady  = v.mrdy;
    endtask

    function automatic out_t read_out();
        out_t o;
        o.fa = hz.ForwardA_E; o.fb = hz.ForwardB_E;
        o.sf = hz.Stall_F; o.sd = hz.Stall_D; o.se = hz.Stall_E; o.sm = hz.Stall_M;
        o.fd = hz.Flush_D; o.fe = hz.Flush_E; o.fw = hz.Flush_W; o.li = hz.LongIssue;
        return o;
    endfunction

    // One clock cycle: drive, sample at the falling edge, compare with model, advance model.
    task automatic run_cycle(string nm, in_t v, output out_t act);
        out_t exp;
        apply(v);
        @(negedge clk);
        act = read_out();
        exp = model_out(v, reset);
        check(nm, 32'(act), 32'(exp));
`ifdef HAZARD_PERF_EN
        check({nm, "_perf_mem"},   32'(hz.PerfMem),   32'(pm));
        check({nm, "_perf_lw"},    32'(hz.PerfLw),    32'(pl));
        check({nm, "_perf_sb"},    32'(hz.PerfSb),    32'(ps));
        check({nm, "_perf_flush"}, 32'(hz.PerfFlush), 32'(pf));
`endif
        model_update(v, reset, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic add(string nm, in_t v, out_t o);
        vec_t t;
        t.name = nm; t.i = v; t.o = o;
        tbl.push_back(t);
    endtask

    initial begin
        in_t  v;
        out_t act;
        int   rem[$];
        int   idx, r;
        bit   in_rem;

        reset = 1'b1;
        apply(idle());
        @(posedge clk);
        #1;
        run_cycle("reset0", idle(), act);
        check("reset_outputs", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0)));
        run_cycle("reset1", idle(), act);
        reset = 1'b0;

        // ---------------- constant vector table ----------------
        v = idle(); v.rs1E = 5; v.rdM = 5; v.wm = 1; v.rdW = 5; v.ww = 1;
        add("fwd_m_prio", v, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.rs1E = 0;
        add("fwd_x0", v, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.rs1E = 3; v.rs2E = 3; v.rdM = 3; v.wm = 0; v.rdW = 3; v.ww = 1;
        add("fwd_w_both", v, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.rs1E = 9; v.rdW = 9; v.ww = 1; v.rs2E = 8; v.rdM = 8; v.wm = 1;
        add("fwd_split", v, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.rs1E = 6; v.rdM = 6; v.rdW = 6;
        add("fwd_no_we", v, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.res = 2'b01; v.rdE = 7; v.rs2D = 7;
        add("lw_use", v, mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        v = idle(); v.res = 2'b01; v.rdE = 0;
        add("lw_x0", v, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.res = 2'b00; v.rdE = 7; v.rs1D = 7;
        add("not_load", v, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.pc = 1;
        add("branch", v, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        v = idle(); v.pc = 1; v.res = 2'b01; v.rdE = 7; v.rs1D = 7;
        add("branch_lw", v, mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
        v.mreq = 1; v.mrdy = 0;
        add("mem_freeze", v, mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 0));
        v = idle(); v.mreq = 1; v.mrdy = 1;
        add("mem_ready", v, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        v = idle(); v.lopE = 1; v.rdE = 12; v.mreq = 1; v.mrdy = 0;
        add("long_blocked_mem", v, mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle({tbl[i].name, "_model"}, tbl[i].i, act);
            check(tbl[i].name, 32'(act), 32'(tbl[i].o));
        end

        // ---------------- load-use lasts one cycle ----------------
        v = idle(); v.res = 2'b01; v.rdE = 7; v.rs2D = 7;
        run_cycle("lu_c1", v, act);
        check("lu_stall_c1", 32'({act.sf, act.sd, act.fe}), 32'(3'b111));
        v.res = 2'b00; v.rdE = 0;       // E now holds the bubble
        run_cycle("lu_c2", v, act);
        check("lu_release_c2", 32'({act.sf, act.sd, act.fe}), 32'(3'b000));

        // ---------------- memory wait with pending branch ----------------
        for (int c = 0; c < 3; c++) begin
            v = idle(); v.mreq = 1; v.mrdy = 0; v.pc = 1;
            run_cycle("memw", v, act);
            check("memw_freeze", 32'({act.sf, act.sd, act.se, act.sm, act.fw, act.fd, act.fe}),
                  32'(7'b1111100));
        end
        v = idle(); v.mreq = 1; v.mrdy = 1; v.pc = 1;
        run_cycle("memw_c4", v, act);
        check("memw_drain_flush", 32'({act.fd, act.fe, act.sm, act.fw}), 32'(4'b1100));

        // ---------------- long op scoreboard ----------------
        v = idle(); v.lopE = 1; v.rdE = 9;
        run_cycle("lo_issue9", v, act);
        check("lo_issue9_li", 32'(act.li), 32'(1));
        v = idle(); v.rs1D = 9;
        run_cycle("lo_wait_a", v, act);
        check("lo_wait_a_sd", 32'(act.sd), 32'(1));
        run_cycle("lo_wait_b", v, act);
        v.ldone = 1; v.lrd = 9;
        run_cycle("lo_done9", v, act);
        check("lo_done9_still_stall", 32'(act.sd), 32'(1));
        v = idle(); v.rs1D = 9;
        run_cycle("lo_release9", v, act);
        check("lo_release9_sd", 32'(act.sd), 32'(0));

        v = idle(); v.lopE = 1; v.rdE = 10;
        run_cycle("lo_issue10", v, act);
        v.rdE = 11;
        run_cycle("lo_issue11", v, act);
        v = idle(); v.lopD = 1;
        run_cycle("lo_full", v, act);
        check("lo_full_sd", 32'(act.sd), 32'(1));
        v.ldone = 1; v.lrd = 10;
        run_cycle("lo_full_done", v, act);
        check("lo_full_done_sd", 32'(act.sd), 32'(1));
        v = idle(); v.lopD = 1;
        run_cycle("lo_slot_free", v, act);
        check("lo_slot_free_sd", 32'(act.sd), 32'(0));

        // same-cycle issue and completion on x4
        v = idle(); v.lopE = 1; v.rdE = 4;
        run_cycle("sc_issue4", v, act);
        v.ldone = 1; v.lrd = 4;
        run_cycle("sc_issue_done4", v, act);
        v = idle(); v.rs1D = 4;
        run_cycle("sc_pend4", v, act);
        check("sc_pend4_sd", 32'(act.sd), 32'(1));
        v = idle(); v.lopD = 1;
        run_cycle("sc_count_full", v, act);
        check("sc_count_full_sd", 32'(act.sd), 32'(1));

        // reset in the middle of outstanding work
        reset = 1'b1;
        v = idle(); v.rs1D = 4; v.lopE = 1; v.rdE = 6;
        run_cycle("mid_reset", v, act);
        check("mid_reset_outputs", 32'(act), 32'(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0)));
        reset = 1'b0;
        v = idle(); v.rs1D = 4; v.rdD = 11; v.lopD = 1;
        run_cycle("post_reset", v, act);
        check("post_reset_sd", 32'(act.sd), 32'(0));

        // ---------------- randomized cycles ----------------
        for (int n = 0; n < 400; n++) begin
            v = idle();
            v.wm   = 1'($urandom_range(0, 1));
            v.ww   = 1'($urandom_range(0, 1));
            v.rdE  = 5'($urandom_range(0, 7));
            v.rdM  = 5'($urandom_range(0, 7));
            v.rdW  = 5'($urandom_range(0, 7));
            v.rs1D = 5'($urandom_range(0, 7));
            v.rs2D = 5'($urandom_range(0, 7));
            v.rs1E = 5'($urandom_range(0, 7));
            v.rs2E = 5'($urandom_range(0, 7));
            v.rdD  = 5'($urandom_range(0, 7));
            v.res  = 2'($urandom_range(0, 3));
            v.pc   = ($urandom_range(0, 5) == 0);
            v.lopD = 1'($urandom_range(0, 1));
            v.mreq = 1'($urandom_range(0, 1));
            v.mrdy = ($urandom_range(0, 3) != 0);
            v.lrd  = 5'($urandom_range(0, 7));
            rem = q;
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx     = $urandom_range(0, q.size() - 1);
                v.ldone = 1'b1;
                v.lrd   = 5'(q[idx]);
                rem.delete(idx);
            end
            if (rem.size() < LD && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 7);
                in_rem = 1'b0;
                foreach (rem[k]) if (rem[k] == r) in_rem = 1'b1;
                if (in_rem) r = 0;
                v.lopE = 1'b1;
                v.rdE  = 5'(r);
            end
            reset = ($urandom_range(0, 60) == 0);
            run_cycle("rand", v, act);
        end
        reset = 1'b0;

`ifdef HAZARD_PERF_EN
        // ---------------- performance counters ----------------
        reset = 1'b1;
        run_cycle("perf_reset", idle(), act);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            v = idle(); v.mreq = 1; v.mrdy = 0;
            run_cycle("perf_mem", v, act);
        end
        check("perf_mem_5", 32'(hz.PerfMem), 32'(5));
        for (int c = 0; c < 20; c++) begin
            v = idle(); v.mreq = 1; v.mrdy = 0;
            run_cycle("perf_sat", v, act);
        end
        check("perf_mem_sat", 32'(hz.PerfMem), 32'(15));
        for (int c = 0; c < 3; c++) begin
            v = idle(); v.pc = 1;
            run_cycle("perf_flush", v, act);
        end
        check("perf_flush_3", 32'(hz.PerfFlush), 32'(3));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
